// File: rtl/datapath.sv
// DE1 execution datapath: PC, IR, accumulator A, add/sub ALU and a unified
// instruction/data memory with a program-load port, steered by CU strobes.
module datapath #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  IRload,
   input  logic                  JMPmux,
   input  logic                  PCload,
   input  logic                  Meminst,
   input  logic                  MemWr,
   input  logic                  Aload,
   input  logic                  Sub,
   input  logic [1:0]            Asel,
   input  logic                  Halt,
   input  logic [DATA_WIDTH-1:0] Input,
   input  logic                  PgmWr,
   input  logic [ADDR_WIDTH-1:0] PgmAddr,
   input  logic [DATA_WIDTH-1:0] PgmData,
   output logic [2:0]            IR,
   output logic                  Aeq0,
   output logic                  Apos,
   output logic [DATA_WIDTH-1:0] Output,
   output logic                  Halted,
   output logic [ADDR_WIDTH-1:0] PC_out
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] ir_q, ir_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic                  halted_q;

   logic [ADDR_WIDTH-1:0] operand;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] alu_result;

   assign operand    = ir_q[ADDR_WIDTH-1:0];
   assign mem_addr   = Meminst ? pc_q : operand;
   assign mem_rdata  = mem_q[mem_addr];
   assign alu_result = Sub ? (a_q - mem_rdata) : (a_q + mem_rdata);

   always_comb begin
      pc_d = pc_q;
      ir_d = ir_q;
      a_d  = a_q;
      if (PCload) begin
         pc_d = JMPmux ? operand : pc_q + ADDR_WIDTH'(1);
      end
      if (IRload) begin
         ir_d = mem_rdata;
      end
      if (Aload) begin
         case (Asel)
            2'b00:   a_d = alu_result;
            2'b01:   a_d = Input;
            2'b10:   a_d = mem_rdata;
            default: a_d = '0;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         halted_q <= Halt;
      end
   end

   // Memory is never cleared; any write sampled while reset is high is dropped.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (PgmWr) begin
            mem_q[PgmAddr] <= PgmData;
         end else if (MemWr) begin
            mem_q[mem_addr] <= a_q;
         end
      end
   end

   assign IR     = ir_q[DATA_WIDTH-1 -: 3];
   assign Aeq0   = (a_q == '0);
   assign Apos   = ~a_q[DATA_WIDTH-1];
   assign Output = a_q;
   assign Halted = halted_q;
   assign PC_out = pc_q;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed scenarios, randomized strobes and a small
// CU emulation, all checked against an arithmetic model of the datapath.
module tb_datapath;

   logic       clock = 1'b0;
   logic       reset;
   logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub;
   logic [1:0] Asel;
   logic       Halt;
   logic [7:0] Input;
   logic       PgmWr;
   logic [4:0] PgmAddr;
   logic [7:0] PgmData;
   logic [2:0] IR;
   logic       Aeq0, Apos, Halted;
   logic [7:0] Output;
   logic [4:0] PC_out;

   datapath #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
      .clock(clock), .reset(reset), .IRload(IRload), .JMPmux(JMPmux),
      .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload),
      .Sub(Sub), .Asel(Asel), .Halt(Halt), .Input(Input), .PgmWr(PgmWr),
      .PgmAddr(PgmAddr), .PgmData(PgmData), .IR(IR), .Aeq0(Aeq0),
      .Apos(Apos), .Output(Output), .Halted(Halted), .PC_out(PC_out)
   );

   // clock / reset
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

   // reference model and scoreboard
   int m_mem [32];
   int m_pc, m_ir, m_a, m_halted;
   logic [7:0] exp_q [$];
   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int addr, rd, n_pc, n_ir, n_a;
      if (reset) begin
         m_pc = 0; m_ir = 0; m_a = 0; m_halted = 0;
         return;
      end
      addr = Meminst ? m_pc : (m_ir % 32);
      rd   = m_mem[addr];
      n_pc = m_pc; n_ir = m_ir; n_a = m_a;
      if (IRload) n_ir = rd;
      if (PCload) n_pc = JMPmux ? (m_ir % 32) : ((m_pc + 1) % 32);
      if (Aload) begin
         case (int'(Asel))
            0: n_a = Sub ? ((m_a - rd + 256) % 256) : ((m_a + rd) % 256);
            1: n_a = int'(Input);
            2: n_a = rd;
            default: n_a = 0;
         endcase
      end
      if (PgmWr) m_mem[PgmAddr] = int'(PgmData);
      else if (MemWr) m_mem[addr] = m_a;
      m_pc = n_pc; m_ir = n_ir; m_a = n_a; m_halted = int'(Halt);
   endtask

   task automatic check_all();
      logic [7:0] e;
      e = exp_q.pop_front();
      chk("out", Output, e);
      chk("pc", PC_out, m_pc);
      chk("ir", IR, m_ir / 32);
      chk("aeq0", Aeq0, (m_a == 0));
      chk("apos", Apos, (m_a < 128));
      chk("halted", Halted, m_halted);
   endtask

   // driver tasks
   task automatic idle();
      IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0;
      Aload = 0; Sub = 0; Asel = 2'b00; Halt = 0; PgmWr = 0;
      PgmAddr = '0; PgmData = '0;
   endtask

   task automatic tick();
      model_edge();
      exp_q.push_back(8'(m_a));
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic pgm_write(input int addr, input int data);
      idle();
      PgmWr = 1; PgmAddr = 5'(addr); PgmData = 8'(data);
      tick();
      idle();
   endtask

   task automatic fetch();
      idle();
      IRload = 1; PCload = 1; Meminst = 1;
      tick();
      idle();
   endtask

   task automatic load_a(input logic [1:0] sel, input logic sub);
      idle();
      Aload = 1; Asel = sel; Sub = sub;
      tick();
      idle();
   endtask

   task automatic jump();
      idle();
      PCload = 1; JMPmux = 1;
      tick();
      idle();
   endtask

   task automatic do_reset();
      idle();
      #2;
      reset = 1;
      m_pc = 0; m_ir = 0; m_a = 0; m_halted = 0;
      #1;
      exp_q.push_back(8'h00);
      check_all();
      tick();
      reset = 0;
   endtask

   // one instruction of a tiny CU: 001 IN, 100 JZ, 111 HALT
   task automatic cu_step();
      fetch();
      case (IR)
         3'b001: load_a(2'b01, 1'b0);
         3'b100: begin
            if (Aeq0) begin PCload = 1; JMPmux = 1; end
            tick();
            idle();
         end
         3'b111: begin
            chk("halted_before", Halted, 0);
            Halt = 1;
            tick();
            chk("halted_after", Halted, 1);
         end
         default: tick();
      endcase
   endtask

   int saved;

   initial begin
      idle();
      reset = 1;
      Input = 8'h00;
      m_pc = 0; m_ir = 0; m_a = 0; m_halted = 0;
      repeat (2) @(posedge clock);
      #1;
      exp_q.push_back(8'h00);
      check_all();
      chk("rst_pc", PC_out, 0);
      chk("rst_aeq0", Aeq0, 1);
      chk("rst_apos", Apos, 1);
      reset = 0;

      for (int i = 0; i < 32; i++) pgm_write(i, $urandom_range(0, 255));
      pgm_write(0, 8'h1F);
      pgm_write(31, 8'h05);
      do_reset();

      fetch();
      chk("fetch_ir", IR, 0);
      chk("fetch_pc", PC_out, 1);
      load_a(2'b10, 1'b0);
      chk("lda_out", Output, 8'h05);
      chk("lda_aeq0", Aeq0, 0);
      chk("lda_apos", Apos, 1);

      pgm_write(31, 8'hFE);
      load_a(2'b00, 1'b0);
      chk("add_wrap", Output, 8'h03);
      pgm_write(31, 8'h05);
      load_a(2'b00, 1'b1);
      chk("sub_wrap", Output, 8'hFE);
      chk("sub_apos", Apos, 0);

      Input = 8'hA5;
      load_a(2'b01, 1'b0);
      chk("in_out", Output, 8'hA5);

      pgm_write(20, 8'h77);
      pgm_write(1, 8'h14);
      fetch();
      MemWr = 1; Aload = 1; Asel = 2'b10;
      tick();
      idle();
      chk("st_read_old", Output, 8'h77);
      load_a(2'b10, 1'b0);
      chk("st_read_new", Output, 8'hA5);

      load_a(2'b11, 1'b0);
      chk("clr_aeq0", Aeq0, 1);
      MemWr = 1; PgmWr = 1; PgmAddr = 5'd20; PgmData = 8'h11;
      tick();
      idle();
      load_a(2'b10, 1'b0);
      chk("pgm_priority", Output, 8'h11);

      pgm_write(2, 8'h09);
      fetch();
      jump();
      chk("jmp_pc", PC_out, 9);
      pgm_write(9, 8'h1F);
      fetch();
      jump();
      chk("jmp_31", PC_out, 31);
      PCload = 1;
      tick();
      idle();
      chk("pc_wrap", PC_out, 0);

      pgm_write(0, 8'h0C);
      fetch();
      jump();
      chk("pc_12", PC_out, 12);
      Input = 8'h3C;
      load_a(2'b01, 1'b0);
      chk("a_3c", Output, 8'h3C);
      saved = m_mem[12];
      #2;
      reset = 1;
      MemWr = 1; PgmWr = 1; PgmAddr = 5'd12; PgmData = 8'hEE;
      m_pc = 0; m_ir = 0; m_a = 0; m_halted = 0;
      #1;
      chk("arst_out", Output, 0);
      chk("arst_pc", PC_out, 0);
      tick();
      idle();
      reset = 0;
      fetch();
      load_a(2'b10, 1'b0);
      chk("arst_mem", Output, saved);

      for (int n = 0; n < 300; n++) begin
         IRload  = 1'($urandom_range(0, 1));
         JMPmux  = 1'($urandom_range(0, 1));
         PCload  = 1'($urandom_range(0, 1));
         Meminst = 1'($urandom_range(0, 1));
         MemWr   = ($urandom_range(0, 3) == 0);
         Aload   = 1'($urandom_range(0, 1));
         Sub     = 1'($urandom_range(0, 1));
         Asel    = 2'($urandom_range(0, 3));
         Halt    = 1'($urandom_range(0, 1));
         Input   = 8'($urandom_range(0, 255));
         PgmWr   = ($urandom_range(0, 7) == 0);
         PgmAddr = 5'($urandom_range(0, 31));
         PgmData = 8'($urandom_range(0, 255));
         tick();
      end
      idle();

      pgm_write(0, 8'h20);
      pgm_write(1, 8'h87);
      pgm_write(2, 8'hE0);
      pgm_write(7, 8'hE0);
      Input = 8'h00;
      do_reset();
      cu_step();
      cu_step();
      chk("cu_jz_taken", PC_out, 7);
      Input = 8'h03;
      do_reset();
      cu_step();
      cu_step();
      chk("cu_jz_not_taken", PC_out, 2);
      cu_step();
      chk("cu_halt_ir", IR, 3'b111);
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Execution datapath paired with the CU control unit in the DE1 processor.
- Consumes the CU control strobes (IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel) and returns the opcode IR[2:0] and the status flags Aeq0/Apos.
- Contains PC, IR, accumulator A, an 8-bit add/sub ALU and a 32x8 unified instruction/data memory.
- Has a program-load port so a bench or top level can fill memory before releasing the CU.

Parameters:
- DATA_WIDTH, 8, width of A, IR and memory words; must equal ADDR_WIDTH+3.
- ADDR_WIDTH, 5, width of PC and the IR operand field; memory depth is 2**ADDR_WIDTH.

Ports:
- clock  input  1  system clock, all registers rise-edge.
- reset  input  1  asynchronous, active-high reset.
- IRload  input  1  load IR from memory data.
- JMPmux  input  1  PC source: 1 = IR operand, 0 = PC+1.
- PCload  input  1  load PC.
- Meminst  input  1  memory address: 1 = PC, 0 = IR operand.
- MemWr  input  1  write A to memory at the selected address.
- Aload  input  1  load A.
- Sub  input  1  ALU: 1 = A-M, 0 = A+M.
- Asel  input  2  A source: 00 ALU, 01 Input, 10 memory data, 11 zero.
- Halt  input  1  CU halt indication.
- Input  input  DATA_WIDTH  switch data for the IN instruction.
- PgmWr  input  1  program-load write strobe.
- PgmAddr  input  ADDR_WIDTH  program-load address.
- PgmData  input  DATA_WIDTH  program-load data.
- IR  output  3  opcode = IR register [DATA_WIDTH-1 -: 3], to CU.
- Aeq0  output  1  A == 0, combinational from A.
- Apos  output  1  ~A[DATA_WIDTH-1] (zero counts as positive).
- Output  output  DATA_WIDTH  A register value.
- Halted  output  1  registered copy of Halt.
- PC_out  output  ADDR_WIDTH  current PC, for debug display.

Behaviour:
- Reset: PC=0, IR register=0, A=0, Halted=0.
  - Hence IR=000, Aeq0=1, Apos=1, Output=0.
  - Memory is not cleared by reset; its contents survive reset.
- Memory:
  - Address = Meminst ? PC : IR[ADDR_WIDTH-1:0].
  - Read is asynchronous (combinational); write is synchronous on the clock edge.
  - MemWr writes A to the addressed word.
  - PgmWr writes PgmData to PgmAddr. PgmWr has priority over MemWr: when both are high in the same cycle, only the PgmWr write happens.
  - A read of a word written in the same cycle returns the old data; the new data appears from the next cycle.
- IR: when IRload=1, the IR register takes the memory read data at the edge.
- PC:
  - When PCload=1: PC <= JMPmux ? IR operand : PC+1.
  - The increment is mod 2**ADDR_WIDTH, so 31 wraps to 0.
  - All next-state values use pre-edge register values. A fetch cycle (IRload=1, PCload=1, JMPmux=0, Meminst=1) therefore loads IR from the old PC and advances PC in the same edge.
- ALU:
  - A + M or A - M, where M is the current memory read data.
  - Result truncated to DATA_WIDTH (modulo wrap); no carry or overflow outputs.
- A: when Aload=1, A <= mux(Asel). With Asel=11, A is cleared.
- Flags: Aeq0 and Apos are purely combinational from A, valid in the same cycle A changes.
- Holding: with all strobes low, every register holds its value.
- Halt: Halted follows Halt with 1-cycle latency. Halt does not gate any strobes; the CU guarantees no strobes are asserted in its halt state.
- Reset mid-operation: registers clear asynchronously, independent of the clock. Memory write strobes sampled on the same edge as reset assertion are ignored; no partial update is allowed.

Test Plan:
- Reset and program load:
  - Assert reset, then PgmWr M[0]=8'h1F, M[31]=8'h05, release reset.
  - Required: PC_out=0, Output=0, Aeq0=1, Apos=1.
  - Memory holds both words after a second reset pulse.
- Fetch then load:
  - Fetch strobes with M[0]=8'h1F: one edge → IR=000, PC_out=1.
  - Then Meminst=0, Aload=1, Asel=10 → Output=8'h05, Aeq0=0, Apos=1.
- Add/sub wrap:
  - A=8'h05, M=8'hFE, Sub=0, Aload=1 → A=8'h03.
  - A=8'h03, M=8'h05, Sub=1 → A=8'hFE, Apos=0.
- Store and input:
  - Asel=01, Input=8'hA5, Aload=1 → A=8'hA5.
  - MemWr=1, Meminst=0, IR operand=5'd20 → M[20]=8'hA5, readable the next cycle.
  - Same cycle with PgmWr=1 to addr 20, data 8'h11 → M[20]=8'h11.
- Jump and wrap:
  - IR operand=5'd9, PCload=1, JMPmux=1 → PC_out=9.
  - PC=31, PCload=1, JMPmux=0 → PC_out=0.
  - Full CU+datapath run of the program "IN, JZ 7, HALT": Input=0 → PC_out=7; Input=3 → halts, Halted=1 one cycle after Halt.
- Async reset mid-run: assert reset between clock edges with A=8'h3C, PC=12 → A=0, PC_out=0 before the next edge; memory unchanged.
